// File: rtl/cache_refill_ctrl.sv
// Line-refill engine: bursts one cache line from the bus into the data RAM.
// Optional macro CACHE_REFILL_CWF_EN selects critical-word-first beat order.
module cache_refill_ctrl #(
    parameter int datawidth   = 64,
    parameter int cache_depth = 2048,
    parameter int line_words  = 8,
    parameter int paddr_wid   = 32,
    localparam int cswidth    = datawidth / 8,
    localparam int addr_lsb   = $clog2(cswidth),
    localparam int addr_wid   = $clog2(cache_depth),
    localparam int lw_bits    = $clog2(line_words)
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         refill_req,
    input  logic [paddr_wid-1:0]         refill_addr,
    output logic                         refill_busy,
    output logic                         refill_done,
    output logic                         refill_err,
    output logic                         bus_req,
    output logic [paddr_wid-1:0]         bus_addr,
    input  logic                         bus_ack,
    input  logic                         bus_err,
    input  logic [datawidth-1:0]         bus_dat_i,
    output logic [addr_wid+addr_lsb-1:0] cache_waddr,
    output logic [datawidth-1:0]         cache_di,
    output logic                         cache_we,
    output logic [cswidth-1:0]           cache_bsel,
    output logic                         fwd_valid,
    output logic [datawidth-1:0]         fwd_data
);

    localparam int off_bits = lw_bits + addr_lsb;
    localparam int wa_wid   = addr_wid + addr_lsb;

    typedef enum logic [1:0] {
        IDLE,
        BURST,
        DONE,
        ERR
    } state_t;

    state_t state, state_nx;

    logic [paddr_wid-1:0] base;
    logic [lw_bits-1:0]   req_word;
    logic [lw_bits-1:0]   word;
    logic [lw_bits-1:0]   cnt;
    logic [lw_bits-1:0]   start_word;
    logic                 accept;
    logic                 last;

    assign accept = (state == BURST) && bus_ack && !bus_err;
    assign last   = accept && (cnt == lw_bits'(line_words - 1));

`ifdef CACHE_REFILL_CWF_EN
    assign start_word = refill_addr[off_bits-1:addr_lsb];
`else
    assign start_word = '0;
`endif

    // Base has its offset bits cleared, so the word offset can never carry upward.
    assign bus_addr   = base | (paddr_wid'(word) << addr_lsb);
    assign cache_bsel = {cswidth{cache_we}};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx    = state;
        refill_busy = 1'b1;
        refill_done = 1'b0;
        refill_err  = 1'b0;
        bus_req     = 1'b0;
        unique case (state)
            IDLE: begin
                refill_busy = 1'b0;
                if (refill_req) state_nx = BURST;
            end
            BURST: begin
                bus_req = 1'b1;
                if (bus_err) state_nx = ERR;
                else if (last) state_nx = DONE;
            end
            DONE: begin
                refill_done = 1'b1;
                state_nx    = IDLE;
            end
            ERR: begin
                refill_err = 1'b1;
                state_nx   = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            base        <= '0;
            req_word    <= '0;
            word        <= '0;
            cnt         <= '0;
            cache_we    <= 1'b0;
            cache_di    <= '0;
            cache_waddr <= '0;
            fwd_valid   <= 1'b0;
            fwd_data    <= '0;
        end else begin
            cache_we  <= accept;
            fwd_valid <= accept && (word == req_word);
            if (state == IDLE && refill_req) begin
                base     <= {refill_addr[paddr_wid-1:off_bits], {off_bits{1'b0}}};
                req_word <= refill_addr[off_bits-1:addr_lsb];
                word     <= start_word;
                cnt      <= '0;
            end
            if (accept) begin
                word        <= word + lw_bits'(1);
                cnt         <= cnt + lw_bits'(1);
                cache_di    <= bus_dat_i;
                cache_waddr <= bus_addr[wa_wid-1:0];
                if (word == req_word) fwd_data <= bus_dat_i;
            end
        end
    end

endmodule
